// File: rtl/univ_shift_reg_burst.sv
// Universal WIDTH-bit shift register (hold/shift right/shift left/load) with a burst
// engine that runs N shifts per start pulse. Optional rotate mode: define ROTATE_EN.
module univ_shift_reg_burst #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             MR,
    input  logic [1:0]       S,
    input  logic             Dsr,
    input  logic             Dsl,
    input  logic [WIDTH-1:0] D,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
`ifdef ROTATE_EN
    input  logic             ROT,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             SO_R,
    output logic             SO_L,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_SHR  = 2'b01;
    localparam logic [1:0] M_SHL  = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rot_live_c;
    logic             rot_burst_c;

`ifdef ROTATE_EN
    logic rot_q, rot_d;
    assign rot_live_c  = ROT;
    assign rot_burst_c = rot_q;
`else
    assign rot_live_c  = 1'b0;
    assign rot_burst_c = 1'b0;
`endif

    // One shift step; left=1 moves bits toward Q[0], rot=1 recirculates the far end.
    function automatic logic [WIDTH-1:0] shift_fn(
        input logic [WIDTH-1:0] q,
        input logic             left,
        input logic             rot,
        input logic             dr,
        input logic             dl
    );
        if (left) begin
            return {(rot ? q[0] : dl), q[WIDTH-1:1]};
        end
        return {q[WIDTH-2:0], (rot ? q[WIDTH-1] : dr)};
    endfunction

    always_ff @(posedge clk or negedge MR) begin
        if (!MR) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef ROTATE_EN
        rot_d   = rot_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start && (S == M_SHR || S == M_SHL)) begin
                    dir_d = (S == M_SHL);
`ifdef ROTATE_EN
                    rot_d = ROT;
`endif
                    // The accepting edge performs the first shift of the burst.
                    if (cnt != '0) begin
                        q_d     = shift_fn(q_q, (S == M_SHL), rot_live_c, Dsr, Dsl);
                        rem_d   = CNT_W'(cnt - CNT_W'(1));
                        state_d = (cnt == CNT_W'(1)) ? ST_DONE : ST_BURST;
                    end else begin
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end
                end else begin
                    case (S)
                        M_HOLD:  q_d = q_q;
                        M_SHR:   q_d = shift_fn(q_q, 1'b0, rot_live_c, Dsr, Dsl);
                        M_SHL:   q_d = shift_fn(q_q, 1'b1, rot_live_c, Dsr, Dsl);
                        M_LOAD:  q_d = D;
                        default: q_d = q_q;
                    endcase
                end
            end
            ST_BURST: begin
                q_d = shift_fn(q_q, dir_q, rot_burst_c, Dsr, Dsl);
                if (rem_q != '0) begin
                    rem_d = CNT_W'(rem_q - CNT_W'(1));
                end
                if (rem_q <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_BURST);
        done_d = (state_d == ST_DONE);
    end

    assign Q    = q_q;
    assign SO_R = q_q[WIDTH-1];
    assign SO_L = q_q[0];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Bench for univ_shift_reg_burst: directed scenarios followed by random traffic,
// all compared each cycle against a shift-count reference model.
module tb_univ_shift_reg_burst;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          MR;
    logic [1:0]    S;
    logic          Dsr, Dsl;
    logic [W-1:0]  D;
    logic          start;
    logic [CW-1:0] cnt;
`ifdef ROTATE_EN
    logic          rot_in;
`endif
    logic [W-1:0]  Q;
    logic          SO_R, SO_L, busy, done;

    int checks = 0;
    int errors = 0;

    // Reference model: register value plus the number of burst shifts still owed.
    logic [W-1:0] m_q;
    int           m_rem;
    logic         m_left, m_rot, m_busy, m_done;

    univ_shift_reg_burst #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .MR    (MR),
        .S     (S),
        .Dsr   (Dsr),
        .Dsl   (Dsl),
        .D     (D),
        .start (start),
        .cnt   (cnt),
`ifdef ROTATE_EN
        .ROT   (rot_in),
`endif
        .Q     (Q),
        .SO_R  (SO_R),
        .SO_L  (SO_L),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] q, input logic left,
                                               input logic rot, input logic dr, input logic dl);
        int v;
        int b;
        v = int'(q);
        if (!left) begin
            b = rot ? int'(q[W-1]) : int'(dr);
            v = ((v * 2) + b) % (1 << W);
        end else begin
            b = rot ? int'(q[0]) : int'(dl);
            v = (v / 2) + b * (1 << (W - 1));
        end
        return W'(v);
    endfunction

    function automatic logic live_rot();
`ifdef ROTATE_EN
        return rot_in;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_q = '0; m_rem = 0; m_left = 1'b0; m_rot = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_edge();
        if (m_rem > 0) begin
            m_q    = ref_shift(m_q, m_left, m_rot, Dsr, Dsl);
            m_rem  = m_rem - 1;
            m_busy = (m_rem > 0);
            m_done = (m_rem == 0);
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start && (S == 2'b01 || S == 2'b10)) begin
            m_left = (S == 2'b10);
            m_rot  = live_rot();
            if (int'(cnt) > 0) begin
                m_q    = ref_shift(m_q, m_left, m_rot, Dsr, Dsl);
                m_rem  = int'(cnt) - 1;
                m_busy = (m_rem > 0);
                m_done = (m_rem == 0);
            end else begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else begin
            case (S)
                2'b01:   m_q = ref_shift(m_q, 1'b0, live_rot(), Dsr, Dsl);
                2'b10:   m_q = ref_shift(m_q, 1'b1, live_rot(), Dsr, Dsl);
                2'b11:   m_q = D;
                default: m_q = m_q;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".Q"},    32'(Q),    32'(m_q));
        check({tag, ".SO_R"}, 32'(SO_R), 32'(m_q[W-1]));
        check({tag, ".SO_L"}, 32'(SO_L), 32'(m_q[0]));
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
        check({tag, ".done"}, 32'(done), 32'(m_done));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset(input string tag);
        #2 MR = 1'b0;
        #1;
        check({tag, ".Q"},    32'(Q),    32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        model_reset();
        #1 MR = 1'b1;
    endtask

    initial begin
        MR = 1'b0; S = 2'b00; Dsr = 1'b0; Dsl = 1'b0; D = '0; start = 1'b0; cnt = '0;
`ifdef ROTATE_EN
        rot_in = 1'b0;
`endif
        model_reset();
        #12;
        check("reset.Q",    32'(Q),    32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        MR = 1'b1;
        @(posedge clk); #1;

        // Parallel load then hold.
        S = 2'b11; D = 4'b1010; step("load");
        check("load.val", 32'(Q), 32'hA);
        S = 2'b00;
        for (int i = 0; i < 3; i++) step("hold");
        check("hold.val", 32'(Q), 32'hA);

        // Asynchronous reset with a non-zero register.
        mid_reset("mr_mid");

        // Plain shift right walks a one toward Q[3].
        S = 2'b11; D = 4'b0001; step("load1");
        S = 2'b01; Dsr = 1'b0;
        step("shr1"); check("shr1.val", 32'(Q), 32'h2);
        step("shr2"); check("shr2.val", 32'(Q), 32'h4);
        step("shr3"); check("shr3.val", 32'(Q), 32'h8);
        check("shr3.SO_R", 32'(SO_R), 32'd1);

        // Burst of 3 left shifts; S changes mid-burst must not matter.
        S = 2'b11; D = 4'b0000; step("load0");
        S = 2'b10; Dsl = 1'b1; cnt = 3'd3; start = 1'b1;
        step("b3_e1"); check("b3_e1.val", 32'(Q), 32'h8); check("b3_e1.busy", 32'(busy), 32'd1);
        start = 1'b0; S = 2'b11; D = 4'b0101;
        step("b3_e2"); check("b3_e2.val", 32'(Q), 32'hC); check("b3_e2.busy", 32'(busy), 32'd1);
        step("b3_e3"); check("b3_e3.val", 32'(Q), 32'hE); check("b3_e3.done", 32'(done), 32'd1);
        check("b3_e3.busy", 32'(busy), 32'd0);
        step("b3_e4"); check("b3_e4.val", 32'(Q), 32'hE); check("b3_e4.done", 32'(done), 32'd0);
        S = 2'b00; step("b3_idle");

        // Zero-length burst, then a start with load mode.
        S = 2'b01; cnt = 3'd0; start = 1'b1;
        step("b0_e1"); check("b0.val", 32'(Q), 32'hE);
        check("b0.busy", 32'(busy), 32'd0); check("b0.done", 32'(done), 32'd1);
        start = 1'b0; S = 2'b00; step("b0_e2");
        S = 2'b11; D = 4'b0110; start = 1'b1; cnt = 3'd5;
        step("ld_start"); check("ld_start.val", 32'(Q), 32'h6); check("ld_start.done", 32'(done), 32'd0);
        start = 1'b0; S = 2'b00; step("ld_after");
        check("ld_after.done", 32'(done), 32'd0);

`ifdef ROTATE_EN
        // Rotate right, then a long rotating burst aborted by reset.
        rot_in = 1'b1; S = 2'b11; D = 4'b1001; step("rot_load");
        S = 2'b01; Dsr = 1'b0; step("rot1"); check("rot1.val", 32'(Q), 32'h3);
        cnt = 3'd7; start = 1'b1; step("rb1");
        start = 1'b0; rot_in = 1'b0; S = 2'b00;
        step("rb2"); step("rb3");
        mid_reset("rb_abort");
        for (int i = 0; i < 3; i++) begin
            step("rb_after");
            check("rb_after.done", 32'(done), 32'd0);
        end
`endif

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            S     = 2'($urandom_range(0, 3));
            Dsr   = 1'($urandom_range(0, 1));
            Dsl   = 1'($urandom_range(0, 1));
            D     = W'($urandom);
            start = ($urandom_range(0, 3) == 0);
            cnt   = CW'($urandom);
`ifdef ROTATE_EN
            rot_in = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 59) == 0) mid_reset("rnd_mr");
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
